slot_timer_arbiter: RTL and testbench
=====================================

// Module: slot_timer_arbiter
// PURPOSE
//  Round-robin arbiter that time-shares one 5-bit slot counter among NUM_REQ requesters.
//  Each winner owns the shared resource for a fixed window of SLOT_LEN clk cycles.
//  slot_end is a one-cycle terminal pulse at the end of each window.
//  Sits between requesting blocks and the shared datapath; grant is a one-hot enable.
// PARAMETERS
//  NUM_REQ   4   number of requesters, 2..8
//  SLOT_LEN  32  cycles per grant window, 1..32
//  ID_W      2   width of grant_id, $clog2(NUM_REQ)
// PORTS
//  clk         in   1        clock, rising edge
//  reset       in   1        asynchronous, active-high reset
//  req         in   NUM_REQ  level request, one bit per requester
//  rel         in   NUM_REQ  early-release strobe; used only with SLOT_EARLY_RELEASE_EN
//  grant       out  NUM_REQ  one-hot grant, registered
//  grant_id    out  ID_W     index of current/last owner, registered
//  slot_count  out  5        cycle index inside current window, 0..SLOT_LEN-1
//  slot_end    out  1        one-cycle pulse, cycle after a window's last grant cycle
//  busy        out  1        1 while in GRANT state
// BEHAVIOUR
//  - Reset (async, immediate): grant=0, grant_id=0, slot_count=0, slot_end=0, busy=0,
//    state=IDLE, rr_ptr=0. Reset mid-window aborts the window; no slot_end pulse.
//  - States: IDLE, GRANT.
//  - IDLE: on each posedge, if req!=0, pick winner = first set req bit searching
//    rr_ptr, rr_ptr+1, ... with wrap mod NUM_REQ.
//    Then grant<=onehot(winner), grant_id<=winner, slot_count<=0, busy<=1,
//    rr_ptr<=(winner+1) mod NUM_REQ, state<=GRANT.
//    If req==0, stay in IDLE with all outputs except grant_id at 0.
//  - Latency: req high at edge N gives grant high from edge N (visible cycle N+1).
//  - GRANT, slot_count<SLOT_LEN-1: slot_count<=slot_count+1, grant held.
//  - GRANT, slot_count==SLOT_LEN-1 (terminal edge): grant<=0, busy<=0, slot_count<=0,
//    slot_end<=1, state<=IDLE.
//  - slot_end is otherwise 0; it is high exactly one cycle.
//  - Back-to-back windows are separated by exactly one IDLE cycle.
//    Arbitration happens in that cycle, concurrent with slot_end=1.
//  - No preemption: deasserting req mid-window does not end the window.
//    New or higher-priority requests wait for the window to end.
//  - SLOT_LEN=1: each window is one grant cycle, then one IDLE cycle.
//  - Counter arithmetic is 5-bit unsigned; slot_count never exceeds SLOT_LEN-1.
//  - Winner index wraps mod NUM_REQ; rr_ptr advances only on a grant.
// CONFIGURATION
//  SLOT_EARLY_RELEASE_EN defined:
//    - In GRANT, rel[grant_id]==1 at an edge is treated as the terminal edge:
//      grant<=0, slot_end<=1, slot_count<=0, state<=IDLE.
//    - rel bits of non-owners are ignored.
//    - rel on a terminal-count edge behaves as a normal terminal edge (single slot_end).
//  SLOT_EARLY_RELEASE_EN undefined:
//    - rel is fully ignored; the port remains present. Windows are always SLOT_LEN cycles.
// TESTING
//  1. Reset held, req=4'b1111 -> all outputs 0. Release reset -> grant=4'b0001 after first edge.
//  2. req=4'b0100 held -> grant=4'b0100 for 32 cycles, slot_count 0..31, then 1 cycle
//     grant=0 with slot_end=1, then grant=4'b0100 again.
//  3. req=4'b1111 held -> grant_id sequence 0,1,2,3,0.
//     req=4'b1010 after owner 1 -> next owner 3, then 1.
//  4. Reset asserted at slot_count=17 -> grant=0, slot_count=0 immediately, no slot_end.
//     After release, grant_id restarts from 0.
//  5. SLOT_LEN=4, NUM_REQ=2, req=2'b11 -> windows of 4 cycles, 1-cycle gaps,
//     alternating owners 0,1.
//  6. rel[owner]=1 at slot_count=5: with SLOT_EARLY_RELEASE_EN, slot_end next cycle.
//     Without it, window runs to slot_count=31.

Source files
------------

// File: rtl/slot_timer_arbiter.sv
// Round-robin arbiter granting a shared resource for fixed SLOT_LEN-cycle windows.
// Optional early release of a window via rel[owner] when SLOT_EARLY_RELEASE_EN is defined.
module slot_timer_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int SLOT_LEN = 32,
  parameter int ID_W     = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] rel,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic [4:0]         slot_count,
  output logic               slot_end,
  output logic               busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam int unsigned N    = NUM_REQ;
  localparam logic [4:0]  LAST = 5'(SLOT_LEN - 1);

  state_t              state, state_n;
  logic [ID_W-1:0]     rr_ptr, rr_ptr_n;
  logic [NUM_REQ-1:0]  grant_n;
  logic [ID_W-1:0]     grant_id_n;
  logic [4:0]          slot_count_n;
  logic                slot_end_n;
  logic                busy_n;

  logic                found;
  logic [ID_W-1:0]     winner;
  logic [ID_W-1:0]     next_ptr;
  logic                term;

  // Search req starting at rr_ptr, wrapping mod NUM_REQ; first hit wins.
  always_comb begin
    int unsigned idx;
    found    = 1'b0;
    winner   = '0;
    next_ptr = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (32'(rr_ptr) + i) % N;
      if (!found && req[idx]) begin
        found    = 1'b1;
        winner   = ID_W'(idx);
        next_ptr = ID_W'((idx + 1) % N);
      end
    end
  end

`ifdef SLOT_EARLY_RELEASE_EN
  assign term = (slot_count == LAST) || rel[grant_id];
`else
  // rel has no effect in this build; it is folded in only to keep the port referenced.
  assign term = (slot_count == LAST) | (1'b0 & (^rel));
`endif

  always_comb begin
    state_n      = state;
    rr_ptr_n     = rr_ptr;
    grant_n      = grant;
    grant_id_n   = grant_id;
    slot_count_n = slot_count;
    slot_end_n   = 1'b0;
    busy_n       = busy;
    unique case (state)
      IDLE: begin
        grant_n      = '0;
        busy_n       = 1'b0;
        slot_count_n = '0;
        if (found) begin
          grant_n[winner] = 1'b1;
          grant_id_n      = winner;
          busy_n          = 1'b1;
          rr_ptr_n        = next_ptr;
          state_n         = GRANT;
        end
      end
      GRANT: begin
        if (term) begin
          grant_n      = '0;
          busy_n       = 1'b0;
          slot_count_n = '0;
          slot_end_n   = 1'b1;
          state_n      = IDLE;
        end else begin
          slot_count_n = slot_count + 5'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      grant      <= '0;
      grant_id   <= '0;
      slot_count <= '0;
      slot_end   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      rr_ptr     <= rr_ptr_n;
      grant      <= grant_n;
      grant_id   <= grant_id_n;
      slot_count <= slot_count_n;
      slot_end   <= slot_end_n;
      busy       <= busy_n;
    end
  end

endmodule

// File: tb/tb_slot_timer_arbiter.sv
// Directed bench for slot_timer_arbiter: default 4x32 instance plus a 2x4 instance.
module tb_slot_timer_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req, rel;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic [4:0] slot_count;
  logic       slot_end, busy;

  logic [1:0] req2, rel2;
  logic [1:0] grant2;
  logic [0:0] grant_id2;
  logic [4:0] slot_count2;
  logic       slot_end2, busy2;

  int errors = 0;
  int checks = 0;

  logic [12:0] obs;
  logic [9:0]  obs2;
  assign obs  = {grant, grant_id, slot_count, slot_end, busy};
  assign obs2 = {grant2, grant_id2, slot_count2, slot_end2, busy2};

  always #5 clk = ~clk;

  slot_timer_arbiter u_a (
    .clk(clk), .reset(reset), .req(req), .rel(rel),
    .grant(grant), .grant_id(grant_id), .slot_count(slot_count),
    .slot_end(slot_end), .busy(busy)
  );

  slot_timer_arbiter #(.NUM_REQ(2), .SLOT_LEN(4), .ID_W(1)) u_b (
    .clk(clk), .reset(reset), .req(req2), .rel(rel2),
    .grant(grant2), .grant_id(grant_id2), .slot_count(slot_count2),
    .slot_end(slot_end2), .busy(busy2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; rel = '0; req2 = '0; rel2 = '0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [12:0] exp;
    reset = 1'b1; req = 4'b1111; rel = '0; req2 = '0; rel2 = '0;
    step(); step();
    exp = '0;
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL reset_hold obs=%b exp=%b", obs, exp); end
    reset = 1'b0;
    step();
    exp = {4'b0001, 2'd0, 5'd0, 1'b0, 1'b1};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL reset_first_grant obs=%b exp=%b", obs, exp); end
  endtask

  task automatic test_full_window();
    logic [12:0] exp;
    do_reset();
    req = 4'b0100;
    step();
    for (int k = 0; k < 32; k++) begin
      if (k != 0) step();
      exp = {4'b0100, 2'd2, 5'(k), 1'b0, 1'b1};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL window_cnt%0d obs=%b exp=%b", k, obs, exp); end
    end
    step();
    exp = {4'b0000, 2'd2, 5'd0, 1'b1, 1'b0};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL window_end obs=%b exp=%b", obs, exp); end
    step();
    exp = {4'b0100, 2'd2, 5'd0, 1'b0, 1'b1};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL window_regrant obs=%b exp=%b", obs, exp); end
  endtask

  task automatic test_round_robin();
    logic [1:0] ids [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [1:0] ids2 [2] = '{2'd3, 2'd1};
    logic [12:0] exp;
    do_reset();
    req = 4'b1111;
    step();
    for (int w = 0; w < 5; w++) begin
      if (w != 0) begin
        repeat (32) step();
        exp = {4'b0000, ids[w-1], 5'd0, 1'b1, 1'b0};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL rr_end%0d obs=%b exp=%b", w, obs, exp); end
        step();
      end
      exp = {4'b0001 << ids[w], ids[w], 5'd0, 1'b0, 1'b1};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL rr_owner%0d obs=%b exp=%b", w, obs, exp); end
    end
    do_reset();
    req = 4'b1111;
    step();
    repeat (33) step();
    exp = {4'b0010, 2'd1, 5'd0, 1'b0, 1'b1};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL rr_owner1 obs=%b exp=%b", obs, exp); end
    req = 4'b1010;
    for (int w = 0; w < 2; w++) begin
      repeat (33) step();
      exp = {4'b0001 << ids2[w], ids2[w], 5'd0, 1'b0, 1'b1};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL rr_sparse%0d obs=%b exp=%b", w, obs, exp); end
    end
  endtask

  task automatic test_reset_mid_window();
    logic [12:0] exp;
    do_reset();
    req = 4'b0001;
    step();
    repeat (17) step();
    exp = {4'b0001, 2'd0, 5'd17, 1'b0, 1'b1};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL mid_cnt17 obs=%b exp=%b", obs, exp); end
    reset = 1'b1;
    #1;
    exp = '0;
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL mid_async_reset obs=%b exp=%b", obs, exp); end
    step();
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL mid_no_slot_end obs=%b exp=%b", obs, exp); end
    req = 4'b1111;
    reset = 1'b0;
    step();
    exp = {4'b0001, 2'd0, 5'd0, 1'b0, 1'b1};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL mid_restart obs=%b exp=%b", obs, exp); end
  endtask

  task automatic test_short_slot();
    logic [9:0] exp;
    do_reset();
    req2 = 2'b11;
    for (int w = 0; w < 4; w++) begin
      step();
      for (int k = 0; k < 4; k++) begin
        if (k != 0) step();
        exp = {2'b01 << (w % 2), 1'(w % 2), 5'(k), 1'b0, 1'b1};
        checks++;
        if (obs2 !== exp) begin errors++; $display("FAIL short_w%0d_cnt%0d obs=%b exp=%b", w, k, obs2, exp); end
      end
      step();
      exp = {2'b00, 1'(w % 2), 5'd0, 1'b1, 1'b0};
      checks++;
      if (obs2 !== exp) begin errors++; $display("FAIL short_end%0d obs=%b exp=%b", w, obs2, exp); end
    end
  endtask

  task automatic test_early_release();
    logic [12:0] exp;
    do_reset();
    req = 4'b0001;
    step();
    repeat (3) step();
    rel = 4'b0010;
    step();
    exp = {4'b0001, 2'd0, 5'd4, 1'b0, 1'b1};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL rel_nonowner obs=%b exp=%b", obs, exp); end
    rel = 4'b0000;
    step();
    rel = 4'b0001;
    step();
    rel = 4'b0000;
`ifdef SLOT_EARLY_RELEASE_EN
    exp = {4'b0000, 2'd0, 5'd0, 1'b1, 1'b0};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL rel_early_end obs=%b exp=%b", obs, exp); end
    step();
    exp = {4'b0001, 2'd0, 5'd0, 1'b0, 1'b1};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL rel_regrant obs=%b exp=%b", obs, exp); end
`else
    exp = {4'b0001, 2'd0, 5'd6, 1'b0, 1'b1};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL rel_ignored obs=%b exp=%b", obs, exp); end
    repeat (25) step();
    exp = {4'b0001, 2'd0, 5'd31, 1'b0, 1'b1};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL rel_cnt31 obs=%b exp=%b", obs, exp); end
    step();
    exp = {4'b0000, 2'd0, 5'd0, 1'b1, 1'b0};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL rel_full_end obs=%b exp=%b", obs, exp); end
`endif
  endtask

  initial begin
    test_reset();
    test_full_window();
    test_round_robin();
    test_reset_mid_window();
    test_short_slot();
    test_early_release();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
